// File: rtl/graytobin_sync_pkg.sv
// Shared definitions for Gray-pointer crossing logic: decode, popcount and
// the warmup/run state encoding used by the synchronizer front ends.
package graytobin_sync_pkg;

    localparam int unsigned MAXW = 32;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } sync_state_t;

    // Callers zero-extend narrower pointers; leading zeros decode to zeros.
    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b = '0;
        b[MAXW-1] = g[MAXW-1];
        for (int unsigned i = 1; i < MAXW; i++) begin
            b[MAXW-1-i] = b[MAXW-i] ^ g[MAXW-1-i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [MAXW-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/graytobin_sync_chain.sv
// Plain multi-flop synchronizer chain with no logic between stages.
module sync_chain #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/graytobin_sync.sv
// Receive-side Gray pointer front end: synchronize, decode to binary, and
// report pointer movement and non-Gray transitions.
module graytobin_sync
    import graytobin_sync_pkg::*;
#(
    parameter int unsigned ADDRLEN     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDRLEN-1:0] grayptr_async,
    input  logic               err_clr,
    output logic [ADDRLEN-1:0] grayptr_sync,
    output logic [ADDRLEN-1:0] binptr,
    output logic               ptr_valid,
    output logic               ptr_change,
    output logic [ADDRLEN-1:0] ptr_step,
    output logic               gray_err
);

    localparam int unsigned CW = $clog2(SYNC_STAGES + 1);

    sync_state_t        state, state_next;
    logic [CW-1:0]      warm_cnt, warm_cnt_next;
    logic [ADDRLEN-1:0] stage_last;
    logic [ADDRLEN-1:0] bin_next;
    logic [ADDRLEN-1:0] step_next;
    logic               change_next;
    logic               err_set;

    sync_chain #(
        .WIDTH  (ADDRLEN),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (grayptr_async),
        .q     (stage_last)
    );

    assign bin_next = ADDRLEN'(gray2bin(MAXW'(stage_last)));

    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        change_next   = 1'b0;
        step_next     = '0;
        err_set       = 1'b0;
        case (state)
            WARMUP: begin
                warm_cnt_next = warm_cnt + 1'b1;
                if (warm_cnt == CW'(SYNC_STAGES)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Compared against the registered outputs, so the first real
                // sample after warmup never strobes.
                change_next = (stage_last != grayptr_sync);
                step_next   = change_next ? (bin_next - binptr) : '0;
                err_set     = popcount(MAXW'(stage_last ^ grayptr_sync)) > 1;
            end
            default: state_next = WARMUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WARMUP;
            warm_cnt     <= '0;
            grayptr_sync <= '0;
            binptr       <= '0;
            ptr_change   <= 1'b0;
            ptr_step     <= '0;
            gray_err     <= 1'b0;
        end else begin
            state        <= state_next;
            warm_cnt     <= warm_cnt_next;
            grayptr_sync <= stage_last;
            binptr       <= bin_next;
            ptr_change   <= change_next;
            ptr_step     <= step_next;
            if (err_set) begin
                gray_err <= 1'b1;
            end else if (err_clr) begin
                gray_err <= 1'b0;
            end
        end
    end

    assign ptr_valid = (state == RUN);

endmodule

// File: tb/tb_graytobin_sync.sv
// Directed bench for graytobin_sync with a history-based reference model.
module tb_graytobin_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] grayptr_async = 4'b0110;
    logic       err_clr = 1'b0;
    logic [3:0] grayptr_sync, binptr, ptr_step;
    logic       ptr_valid, ptr_change, gray_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    graytobin_sync #(.ADDRLEN(4), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .grayptr_async (grayptr_async),
        .err_clr       (err_clr),
        .grayptr_sync  (grayptr_sync),
        .binptr        (binptr),
        .ptr_valid     (ptr_valid),
        .ptr_change    (ptr_change),
        .ptr_step      (ptr_step),
        .gray_err      (gray_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decode table built from the binary->Gray encoding,
    // outputs derived from the history of samples taken since reset release.
    logic [3:0] g2b [16];
    initial for (int b = 0; b < 16; b++) g2b[4'(b ^ (b >> 1))] = 4'(b);

    logic [3:0] hist[$];
    int unsigned edges;
    logic [3:0] m_sync, m_bin, m_step;
    logic       m_valid, m_chg, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            hist.delete();
            m_sync = '0; m_bin = '0; m_step = '0;
            m_valid = 1'b0; m_chg = 1'b0; m_err = 1'b0;
        end else begin
            logic set;
            edges++;
            hist.push_front(grayptr_async);
            if (hist.size() > 4) void'(hist.pop_back());
            m_valid = (edges >= 3);
            set = 1'b0;
            m_chg = 1'b0;
            m_step = '0;
            if (edges >= 3) begin
                m_sync = hist[2];
                m_bin  = g2b[hist[2]];
            end
            if (edges >= 4) begin
                m_chg  = (hist[2] != hist[3]);
                m_step = m_chg ? 4'(m_bin - g2b[hist[3]]) : 4'd0;
                set    = ($countones(hist[2] ^ hist[3]) > 1);
            end
            if (set) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("sync",   32'(grayptr_sync), 32'(m_sync));
        chk("binptr", 32'(binptr),       32'(m_bin));
        chk("valid",  32'(ptr_valid),    32'(m_valid));
        chk("change", 32'(ptr_change),   32'(m_chg));
        chk("step",   32'(ptr_step),     32'(m_step));
        chk("err",    32'(gray_err),     32'(m_err));
    end

    typedef struct {
        logic [3:0] g;
        logic       clr;
        logic [3:0] bin;
        logic       chg;
        logic [3:0] step;
        logic       err;
    } vec_t;

    // Expected outputs after each edge reflect the input two edges earlier.
    vec_t vecs[] = '{
        '{4'b0000, 1'b0, 4'd4,  1'b0, 4'd0,  1'b0},
        '{4'b0000, 1'b0, 4'd4,  1'b0, 4'd0,  1'b0},
        '{4'b0000, 1'b0, 4'd0,  1'b1, 4'd12, 1'b1},
        '{4'b0000, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0},
        '{4'b0001, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0},
        '{4'b0011, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0},
        '{4'b0010, 1'b0, 4'd1,  1'b1, 4'd1,  1'b0},
        '{4'b1000, 1'b0, 4'd2,  1'b1, 4'd1,  1'b0},
        '{4'b1000, 1'b0, 4'd3,  1'b1, 4'd1,  1'b0},
        '{4'b0000, 1'b0, 4'd15, 1'b1, 4'd12, 1'b1},
        '{4'b0001, 1'b1, 4'd15, 1'b0, 4'd0,  1'b0},
        '{4'b0010, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0},
        '{4'b0010, 1'b0, 4'd1,  1'b1, 4'd1,  1'b0},
        '{4'b0010, 1'b0, 4'd3,  1'b1, 4'd2,  1'b1},
        '{4'b0010, 1'b0, 4'd3,  1'b0, 4'd0,  1'b1},
        '{4'b0010, 1'b1, 4'd3,  1'b0, 4'd0,  1'b0},
        '{4'b0111, 1'b0, 4'd3,  1'b0, 4'd0,  1'b0},
        '{4'b0111, 1'b0, 4'd3,  1'b0, 4'd0,  1'b0},
        '{4'b0111, 1'b1, 4'd5,  1'b1, 4'd2,  1'b1},
        '{4'b0111, 1'b0, 4'd5,  1'b0, 4'd0,  1'b1},
        '{4'b0111, 1'b1, 4'd5,  1'b0, 4'd0,  1'b0}
    };

    task automatic cyc(input logic [3:0] g, input logic clr);
        grayptr_async = g;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sync"},   32'(grayptr_sync), 32'h0);
        chk({tag, "_binptr"}, 32'(binptr),       32'h0);
        chk({tag, "_valid"},  32'(ptr_valid),    32'h0);
        chk({tag, "_change"}, 32'(ptr_change),   32'h0);
        chk({tag, "_step"},   32'(ptr_step),     32'h0);
        chk({tag, "_err"},    32'(gray_err),     32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        cyc(4'b0110, 1'b0);
        chk("warm_e1_valid", 32'(ptr_valid), 32'h0);
        cyc(4'b0110, 1'b0);
        chk("warm_e2_valid", 32'(ptr_valid), 32'h0);
        cyc(4'b0110, 1'b0);
        chk("warm_e3_valid",  32'(ptr_valid),  32'h1);
        chk("warm_e3_binptr", 32'(binptr),     32'h4);
        chk("warm_e3_change", 32'(ptr_change), 32'h0);
        chk("warm_e3_err",    32'(gray_err),   32'h0);

        foreach (vecs[i]) begin
            cyc(vecs[i].g, vecs[i].clr);
            chk($sformatf("vec%0d_binptr", i), 32'(binptr),     32'(vecs[i].bin));
            chk($sformatf("vec%0d_change", i), 32'(ptr_change), 32'(vecs[i].chg));
            chk($sformatf("vec%0d_step", i),   32'(ptr_step),   32'(vecs[i].step));
            chk($sformatf("vec%0d_err", i),    32'(gray_err),   32'(vecs[i].err));
        end
        err_clr = 1'b0;

        // Asynchronous reset mid-cycle while binptr holds 5.
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b0111, 1'b0);
        chk("rewarm_e1_valid", 32'(ptr_valid), 32'h0);
        cyc(4'b0111, 1'b0);
        chk("rewarm_e2_valid", 32'(ptr_valid), 32'h0);
        cyc(4'b0111, 1'b0);
        chk("rewarm_e3_valid",  32'(ptr_valid),  32'h1);
        chk("rewarm_e3_binptr", 32'(binptr),     32'h5);
        chk("rewarm_e3_change", 32'(ptr_change), 32'h0);
        cyc(4'b0111, 1'b0);
        chk("rewarm_e4_change", 32'(ptr_change), 32'h0);

        for (int i = 0; i < 20; i++) begin
            cyc(4'b0111, 1'b0);
            chk("stable_change", 32'(ptr_change), 32'h0);
            chk("stable_step",   32'(ptr_step),   32'h0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
